// File: rtl/miso_combiner_n_pkg.sv
// rtl/miso_combiner_n_pkg.sv - shared types, widths and saturation helpers for the MISO combiner
package miso_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_GW        = 8;
  localparam int unsigned DEF_GAIN_FRAC = 6;
  localparam int unsigned WIDE_W        = 64;

  typedef logic signed [DEF_W-1:0]  sample_t;
  typedef logic signed [DEF_GW-1:0] gain_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int unsigned acc_width(input int unsigned n, input int unsigned w,
                                            input int unsigned gw);
    return w + gw + $clog2(n);
  endfunction

  function automatic int unsigned gain_one(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  localparam gain_t GAIN_ONE = gain_t'(gain_one(DEF_GAIN_FRAC));

  // Bounds are computed at 64 bits so any result width up to 63 can be clamped.
  function automatic wide_t sat_clamp(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic sat_hit(input wide_t v, input int unsigned w);
    return (sat_clamp(v, w) != v);
  endfunction

endpackage

// File: rtl/miso_combiner_n_if.sv
// rtl/miso_combiner_n_if.sv - sample, configuration and output bundle of the MISO combiner
interface miso_combiner_n_if #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int GW    = 8,
  parameter int DEPTH = 16
);
  localparam int SW = $clog2(N);
  localparam int DW = $clog2(DEPTH);

  logic                 in_valid;
  logic [N*W-1:0]       in_data;
  logic                 cfg_we;
  logic [SW-1:0]        cfg_sel;
  logic [DW-1:0]        cfg_delay;
  logic signed [GW-1:0] cfg_gain;
  logic                 out_valid;
  logic signed [W-1:0]  out_data;
  logic                 sat_flag;

  modport master (
    output in_valid, in_data, cfg_we, cfg_sel, cfg_delay, cfg_gain,
    input  out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_sel, cfg_delay, cfg_gain,
    output out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/miso_combiner_n_delay_line.sv
// rtl/miso_combiner_n_delay_line.sv - one path's circular sample history with zero-delay bypass
module miso_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
  input  logic signed [W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   delay_i,
  output logic signed [W-1:0]        rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic signed [W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_ptr_i] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointer subtraction wraps naturally.
  always_comb begin
    rd_ptr  = wr_ptr_i - delay_i;
    rdata_o = (delay_i == '0) ? wdata_i : mem_q[rd_ptr];
  end

endmodule

// File: rtl/miso_combiner_n.sv
// rtl/miso_combiner_n.sv - N-path delay/gain/sum combiner, 3-clock pipeline; MISO_SAT_EN selects clamp vs wrap
module miso_combiner_n
  import miso_pkg::*;
#(
  parameter int N         = 2,
  parameter int W         = 8,
  parameter int GW        = 8,
  parameter int GAIN_FRAC = 6,
  parameter int DEPTH     = 16
) (
  input  logic               clk,
  input  logic               rst,
  miso_combiner_n_if.slave   bus
);
  localparam int SW = $clog2(N);
  localparam int DW = $clog2(DEPTH);
  localparam int PW = W + GW;
  localparam int AW = acc_width(N, W, GW);
  localparam logic signed [GW-1:0] G1 = GW'(gain_one(GAIN_FRAC));

  logic [DW-1:0]        wr_ptr_q;
  logic [DW-1:0]        delay_q [N];
  logic signed [GW-1:0] gain_q  [N];
  logic signed [W-1:0]  x       [N];
  logic                 cfg_ok;

  if ((1 << SW) > N) begin : g_sel_chk
    assign cfg_ok = bus.cfg_we && (int'(bus.cfg_sel) < N);
  end else begin : g_sel_all
    assign cfg_ok = bus.cfg_we;
  end

  for (genvar i = 0; i < N; i++) begin : g_path
    miso_delay_line #(.W(W), .DEPTH(DEPTH)) u_dl (
      .clk      (clk),
      .rst      (rst),
      .we_i     (bus.in_valid),
      .wr_ptr_i (wr_ptr_q),
      .wdata_i  (bus.in_data[i*W +: W]),
      .delay_i  (delay_q[i]),
      .rdata_o  (x[i])
    );
  end

  // Config lands on the edge that also samples the current beat, so that beat sees the old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < N; i++) begin
        delay_q[i] <= '0;
        gain_q[i]  <= G1;
      end
    end else begin
      if (bus.in_valid) wr_ptr_q <= wr_ptr_q + DW'(1);
      if (cfg_ok) begin
        delay_q[bus.cfg_sel] <= bus.cfg_delay;
        gain_q[bus.cfg_sel]  <= bus.cfg_gain;
      end
    end
  end

  logic signed [PW-1:0] p_d [N];
  logic signed [PW-1:0] p_q [N];
  logic                 v1_q;

  always_comb begin
    for (int i = 0; i < N; i++) p_d[i] = PW'(x[i]) * PW'(gain_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int i = 0; i < N; i++) p_q[i] <= '0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < N; i++) p_q[i] <= p_d[i];
      end
    end
  end

  logic signed [AW-1:0] sum_d;
  logic signed [AW-1:0] sum_q;
  logic                 v2_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) sum_d = sum_d + AW'(p_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) sum_q <= sum_d;
    end
  end

  logic signed [AW-1:0] shifted;
  logic signed [W-1:0]  out_d;
  logic                 sat_d;

  always_comb begin
    shifted = sum_q >>> GAIN_FRAC;
`ifdef MISO_SAT_EN
    out_d = W'(sat_clamp(wide_t'(shifted), W));
    sat_d = sat_hit(wide_t'(shifted), W);
`else
    out_d = W'(shifted);
    sat_d = 1'b0;
`endif
  end

  logic                out_valid_q;
  logic signed [W-1:0] out_data_q;
  logic                sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      sat_q       <= v2_q ? sat_d : 1'b0;
      if (v2_q) out_data_q <= out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: doc/miso_combiner_n.md
Name: miso_combiner_n

Overview:
- Parametrised successor to the two-path 8-bit MISO multipath combiner.
- Combines N signed sample streams into one output stream.
- Each path gets a programmable integer delay (circular buffer) and a signed fixed-point gain; the weighted paths are summed in a pipeline.
- Result is rounded by arithmetic shift, then saturated to W bits.
- Sits between the per-path receive front ends and the voice decoder in the channel simulation.

Parameters:
- N, 2, number of input paths (>=2).
- W, 8, sample width (signed two's complement).
- GW, 8, gain coefficient width (signed).
- GAIN_FRAC, 6, fractional bits of gain; gain 1.0 = 2^GAIN_FRAC.
- DEPTH, 16, delay-line entries per path; must be a power of two; max delay DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample beat valid.
- in_data  in  N*W  packed samples; path i at bits [i*W +: W].
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  $clog2(N)  path index for cfg write.
- cfg_delay  in  $clog2(DEPTH)  delay in beats for the selected path.
- cfg_gain  in  GW  signed gain for the selected path.
- out_valid  out  1  output sample valid.
- out_data  out  W  combined signed sample.
- sat_flag  out  1  clipping occurred on this output beat; qualified by out_valid.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, sat_flag=0.
  - All delay-line entries = 0; write pointer = 0.
  - Every path delay = 0; every path gain = 2^GAIN_FRAC (1.0).
  - Pipeline valid bits cleared.
- Delay line:
  - On each in_valid beat, each path writes its sample at wr_ptr; wr_ptr increments mod DEPTH (wrap, no full/empty state; buffer always holds the last DEPTH beats).
  - Delay d selects the sample accepted d valid beats earlier; d=0 is the current sample (write-through bypass).
  - Delays are counted in valid beats, not clocks; gaps in in_valid do not age the history.
- Pipeline, fixed latency 3 clocks from in_valid to out_valid:
  - S1: fetch delayed sample x_i; p_i = x_i * g_i (W+GW bits signed).
  - S2: sum all p_i into W+GW+$clog2(N) bits, no overflow possible.
  - S3: arithmetic shift right by GAIN_FRAC (floor toward -inf), then saturate or wrap (see Optional Feature); register out_data, sat_flag, out_valid.
- out_valid is asserted one clock per accepted beat. out_data holds its last value when out_valid=0; sat_flag=0 when out_valid=0.
- Configuration:
  - cfg_we takes effect on the next clock edge and applies to samples entering S1 after that edge.
  - cfg_we with in_valid in the same cycle: the current beat uses the old configuration.
  - cfg_sel >= N: write ignored.
- Back-to-back in_valid: full throughput, one output per clock, no stalls, no backpressure.
- Reset mid-operation: in-flight beats are discarded; out_valid drops immediately. The first post-reset outputs see zero history on delayed paths.

Optional Feature:
- Macro MISO_SAT_EN.
- Defined: shifted sum is clamped to [-2^(W-1), 2^(W-1)-1]; sat_flag=1 on beats where clamping occurred.
- Undefined: out_data = low W bits of the shifted sum (wrap); sat_flag tied 0. Latency is unchanged.

Decomposition:
- Package miso_pkg:
  - Sample and gain typedefs.
  - Accumulator width function (W+GW+$clog2(N)).
  - GAIN_ONE constant.
  - Saturate function (width-generic).
- Sub-module miso_delay_line, instantiated N times via generate: one path's DEPTH x W RAM, with write on in_valid and read at (wr_ptr - d) mod DEPTH with d=0 bypass. The top holds the shared wr_ptr, config registers, multipliers, adder tree and S3.

Test Plan (N=2, W=8, GW=8, GAIN_FRAC=6, DEPTH=16):
1. After reset, in_data={0x55,0x55}, in_valid one beat -> 3 clocks later out_valid=1, out_data=127, sat_flag=1 (170 clipped; macro defined).
2. Gains set to 32 (0.5) on both paths; inputs {127,127} -> out 127, sat_flag=0; inputs {0x55,0x55} -> out 85.
3. Gains 32/32, path1 delay=2; impulse {64,64} then zeros on consecutive beats -> outputs 32, 0, 32, 0.
4. Gains 1.0, inputs {-128,-128} -> out -128, sat_flag=1. Without MISO_SAT_EN -> out 0, sat_flag=0.
5. Scenario 3 repeated with in_valid gaps of 0-3 idle clocks -> same output sequence, one out_valid per input beat, each exactly 3 clocks after its input.
6. rst asserted with three beats in flight -> out_valid=0 the same cycle. After release, path1 delay=0 and gain=64: beat {10,20} -> out 30.
